umstr_arp_rx_parser: RTL

- Downstream consumer of the ARP branch of the receive stream splitter: accepts whole Ethernet frames (32-bit AXI-Stream, tkeep) and validates Ethernet and ARP header fields.
- Every qualifying ARP request/reply is emitted as one parallel record on a valid/ready interface for the ARP table/responder.
- Non-ARP, malformed or foreign-addressed frames are consumed and dropped; one-cycle pulses report accepted and dropped frames.

---
 rtl/umstr_arp_rx_parser_pkg.sv | 42 ++++
 rtl/umstr_arp_rx_parser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/umstr_arp_rx_parser_pkg.sv
// -----------------------------------------------------------------------------
// umstr_arp_pkg
// Shared constants and types for the ARP receive path. The record type
// arp_rec_t is also consumed by the ARP table/responder, so its field order
// (oper, sha, spa, tha, tpa) must stay stable.
// -----------------------------------------------------------------------------
package umstr_arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REP   = 16'd2;

  // Beats needed to carry the complete Ethernet + ARP header; the word
  // counter saturates here so arbitrarily long padded frames never wrap it.
  localparam logic [3:0]  ARP_MIN_WORDS  = 4'd11;
  // Beat carrying the low half of the target IP (last header beat).
  localparam logic [3:0]  ARP_TPA_WORD   = 4'd10;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_rec_t;

  typedef enum logic [1:0] {
    ST_PARSE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } arp_rx_state_t;

  // Only requests and replies are forwarded to the responder.
  function automatic logic arp_oper_valid(input logic [15:0] oper);
    return (oper == ARP_OPER_REQ) || (oper == ARP_OPER_REP);
  endfunction

endpackage

// File: rtl/umstr_arp_rx_parser.sv
// -----------------------------------------------------------------------------
// umstr_arp_rx_parser
// Parses whole Ethernet frames arriving on a 32-bit AXI-Stream (first wire byte
// in [31:24]) and forwards every well-formed ARP request/reply addressed to us
// as one parallel record on a valid/ready interface. Everything else is
// consumed and dropped.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   local_mac_i/local_ip_i  own addresses (quasi-static)
//   s_tdata_i/s_tvld_i/s_tlast_i/s_tkeep_i/s_trdy_o   frame input stream
//   arp_vld_o/arp_rdy_i     record handshake
//   arp_oper_o/sha/spa/tha/tpa   record fields, stable while arp_vld_o = 1
//   ok_pulse_o              1 cycle when a record is loaded
//   drop_pulse_o            1 cycle when a frame is discarded
// -----------------------------------------------------------------------------
module umstr_arp_rx_parser
  import umstr_arp_pkg::*;
#(
  parameter bit CHECK_DST_MAC = 1'b1,
  parameter bit CHECK_TPA     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] local_mac_i,
  input  logic [31:0] local_ip_i,
  input  logic [31:0] s_tdata_i,
  input  logic        s_tvld_i,
  input  logic        s_tlast_i,
  input  logic [3:0]  s_tkeep_i,
  output logic        s_trdy_o,
  output logic        arp_vld_o,
  input  logic        arp_rdy_i,
  output logic [15:0] arp_oper_o,
  output logic [47:0] arp_sha_o,
  output logic [31:0] arp_spa_o,
  output logic [47:0] arp_tha_o,
  output logic [31:0] arp_tpa_o,
  output logic        ok_pulse_o,
  output logic        drop_pulse_o
);

  arp_rx_state_t r_state;
  logic [3:0]    r_word_cnt;
  logic          r_err;
  logic          r_dst_bc;
  logic          r_dst_me;
  logic          r_trdy;
  logic          r_vld;
  logic          r_ok;
  logic          r_drop;
  arp_rec_t      r_rec;

  logic          w_beat;
  logic          w_beat_err;
  logic          w_err_acc;
  logic [3:0]    w_cnt_inc;
  logic [15:0]   w_hi;
  logic [15:0]   w_lo;
  logic          w_unused_keep;

  assign w_hi   = s_tdata_i[31:16];
  assign w_lo   = s_tdata_i[15:0];
  assign w_beat = s_tvld_i & r_trdy;

  // Low keep bits only cover padding/FCS bytes and carry no header data.
  assign w_unused_keep = ^s_tkeep_i[1:0];

  // A new frame starts with word 0, which discards the previous sticky error.
  assign w_err_acc = ((r_word_cnt == 4'd0) ? 1'b0 : r_err) | w_beat_err;

  assign w_cnt_inc = (r_word_cnt == ARP_MIN_WORDS) ? ARP_MIN_WORDS
                                                   : (r_word_cnt + 4'd1);

  // Per-beat header checks, only meaningful for beats accepted in PARSE.
  always_comb begin
    w_beat_err = 1'b0;
    case (r_word_cnt)
      4'd1: begin
        // Destination must be entirely broadcast or entirely our MAC; the
        // upper-word matches were recorded on word 0.
        if (CHECK_DST_MAC) begin
          w_beat_err = !((r_dst_bc && (w_hi == 16'hFFFF)) ||
                         (r_dst_me && (w_hi == local_mac_i[15:0])));
        end else begin
          w_beat_err = 1'b0;
        end
      end
      4'd3: w_beat_err = (w_hi != ETHERTYPE_ARP) || (w_lo != ARP_HTYPE_ETH);
      4'd4: w_beat_err = (w_hi != ARP_PTYPE_IPV4) ||
                         (s_tdata_i[15:8] != ARP_HLEN_ETH) ||
                         (s_tdata_i[7:0] != ARP_PLEN_IPV4);
      4'd5: w_beat_err = !arp_oper_valid(w_hi);
      ARP_TPA_WORD: begin
        // A frame ending here must still carry both tpa bytes.
        w_beat_err = (CHECK_TPA && ({r_rec.tpa[31:16], w_hi} != local_ip_i)) ||
                     (s_tlast_i && (s_tkeep_i[3:2] != 2'b11));
      end
      default: w_beat_err = 1'b0;
    endcase
  end

  // Frame FSM with registered handshake, record-valid and pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_PARSE;
      r_word_cnt <= 4'd0;
      r_err      <= 1'b0;
      r_dst_bc   <= 1'b0;
      r_dst_me   <= 1'b0;
      r_trdy     <= 1'b1;
      r_vld      <= 1'b0;
      r_ok       <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_ok   <= 1'b0;
      r_drop <= 1'b0;
      case (r_state)
        ST_PARSE: begin
          if (w_beat) begin
            r_err      <= w_err_acc;
            r_word_cnt <= w_cnt_inc;
            if (r_word_cnt == 4'd0) begin
              r_dst_bc <= (s_tdata_i == 32'hFFFF_FFFF);
              r_dst_me <= (s_tdata_i == local_mac_i[47:16]);
            end
            if (s_tlast_i) begin
              r_word_cnt <= 4'd0;
              if ((r_word_cnt < ARP_TPA_WORD) || w_err_acc) begin
                r_drop <= 1'b1;
              end else begin
                r_state <= ST_EMIT;
                r_vld   <= 1'b1;
                r_ok    <= 1'b1;
                r_trdy  <= 1'b0;
              end
            end else if (r_word_cnt == ARP_TPA_WORD) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Padding and FCS beats: consumed without inspection.
          if (w_beat) begin
            r_word_cnt <= w_cnt_inc;
            if (s_tlast_i) begin
              r_word_cnt <= 4'd0;
              if (r_err) begin
                r_drop  <= 1'b1;
                r_state <= ST_PARSE;
              end else begin
                r_state <= ST_EMIT;
                r_vld   <= 1'b1;
                r_ok    <= 1'b1;
                r_trdy  <= 1'b0;
              end
            end
          end
        end
        ST_EMIT: begin
          if (arp_rdy_i) begin
            r_state <= ST_PARSE;
            r_vld   <= 1'b0;
            r_trdy  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_PARSE;
          r_word_cnt <= 4'd0;
          r_vld      <= 1'b0;
          r_trdy     <= 1'b1;
        end
      endcase
    end
  end

  // Record capture; only header beats in PARSE write, so the record is frozen
  // during DRAIN and EMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec <= '0;
    end else if ((r_state == ST_PARSE) && w_beat) begin
      case (r_word_cnt)
        4'd5: begin
          r_rec.oper        <= w_hi;
          r_rec.sha[47:32]  <= w_lo;
        end
        4'd6: r_rec.sha[31:0] <= s_tdata_i;
        4'd7: r_rec.spa       <= s_tdata_i;
        4'd8: r_rec.tha[47:16] <= s_tdata_i;
        4'd9: begin
          r_rec.tha[15:0]  <= w_hi;
          r_rec.tpa[31:16] <= w_lo;
        end
        ARP_TPA_WORD: r_rec.tpa[15:0] <= w_hi;
        default: r_rec <= r_rec;
      endcase
    end else begin
      r_rec <= r_rec;
    end
  end

  assign s_trdy_o     = r_trdy;
  assign arp_vld_o    = r_vld;
  assign ok_pulse_o   = r_ok;
  assign drop_pulse_o = r_drop;
  assign arp_oper_o   = r_rec.oper;
  assign arp_sha_o    = r_rec.sha;
  assign arp_spa_o    = r_rec.spa;
  assign arp_tha_o    = r_rec.tha;
  assign arp_tpa_o    = r_rec.tpa;

endmodule
